// File: rtl/spi_master_with_single_cs.sv
// SPI master with one active-low chip select: bursts of 1..MAX_BYTES_PER_CS bytes per CS assertion.
// Define SPI_LSB_FIRST_EN to shift LSB first on both MOSI and MISO (default: MSB first).
module spi_master_with_single_cs #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 2,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic          o_SPI_Clk,
    input  logic          i_SPI_MISO,
    output logic          o_SPI_MOSI,
    output logic          o_SPI_CS_n
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   HW   = $clog2(CLKS_PER_HALF_BIT);
    localparam int   IW   = (CS_INACTIVE_CLKS > 0) ? $clog2(CS_INACTIVE_CLKS + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_TRANSFER, ST_CS_INACTIVE} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_remaining, w_remaining_next;
    logic [IW-1:0] r_inactive, w_inactive_next;
    logic          r_cs_n, w_cs_n_next;
    logic [CW-1:0] r_rx_count;
    logic [CW-1:0] w_count_eff;

    logic          r_busy;
    logic [HW-1:0] r_clk_cnt;
    logic [4:0]    r_edge_cnt;
    logic          r_spi_clk, r_mosi, r_rx_dv;
    logic [7:0]    r_tx_shift, r_rx_shift, r_rx_byte;

    logic w_ready_base, w_accept;
    logic w_edge, w_leading, w_trailing, w_last_edge, w_sample, w_drive;
    logic       w_first_bit, w_out_bit;
    logic [7:0] w_load_after, w_shift_next, w_rx_next;

    assign w_ready_base = (r_state == ST_IDLE) ||
                          ((r_state == ST_TRANSFER) && !r_busy && (r_remaining != '0));
    assign w_accept     = w_ready_base && i_TX_DV;
    assign o_TX_Ready   = w_ready_base && !i_TX_DV;

    // Edge numbering counts down from 16: even counts are leading edges, odd are trailing.
    assign w_edge      = r_busy && (r_clk_cnt == HW'(CLKS_PER_HALF_BIT - 1));
    assign w_leading   = w_edge && !r_edge_cnt[0];
    assign w_trailing  = w_edge && r_edge_cnt[0];
    assign w_last_edge = w_edge && (r_edge_cnt == 5'd1);
    assign w_sample    = CPHA ? w_trailing : w_leading;
    assign w_drive     = CPHA ? w_leading  : w_trailing;

`ifdef SPI_LSB_FIRST_EN
    assign w_first_bit  = i_TX_Byte[0];
    assign w_load_after = {1'b0, i_TX_Byte[7:1]};
    assign w_out_bit    = r_tx_shift[0];
    assign w_shift_next = {1'b0, r_tx_shift[7:1]};
    assign w_rx_next    = {i_SPI_MISO, r_rx_shift[7:1]};
`else
    assign w_first_bit  = i_TX_Byte[7];
    assign w_load_after = {i_TX_Byte[6:0], 1'b0};
    assign w_out_bit    = r_tx_shift[7];
    assign w_shift_next = {r_tx_shift[6:0], 1'b0};
    assign w_rx_next    = {r_rx_shift[6:0], i_SPI_MISO};
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_busy     <= 1'b0;
            r_clk_cnt  <= '0;
            r_edge_cnt <= '0;
            r_spi_clk  <= CPOL;
            r_mosi     <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_clk_cnt  <= '0;
                r_edge_cnt <= 5'd16;
                r_spi_clk  <= CPOL;
                if (CPHA) begin
                    r_tx_shift <= i_TX_Byte;
                end else begin
                    r_mosi     <= w_first_bit;
                    r_tx_shift <= w_load_after;
                end
            end else if (r_busy) begin
                if (w_edge) begin
                    r_clk_cnt  <= '0;
                    r_edge_cnt <= r_edge_cnt - 5'd1;
                    r_spi_clk  <= ~r_spi_clk;
                    if (w_drive) begin
                        r_mosi     <= w_out_bit;
                        r_tx_shift <= w_shift_next;
                    end
                    if (w_sample) begin
                        r_rx_shift <= w_rx_next;
                    end
                    // With CPHA=1 the final bit is captured on this very edge.
                    if (w_last_edge) begin
                        r_busy    <= 1'b0;
                        r_rx_dv   <= 1'b1;
                        r_rx_byte <= w_sample ? w_rx_next : r_rx_shift;
                    end
                end else begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_count_eff = i_TX_Count;
        if (i_TX_Count == '0) begin
            w_count_eff = CW'(1);
        end else if (i_TX_Count > CW'(MAX_BYTES_PER_CS)) begin
            w_count_eff = CW'(MAX_BYTES_PER_CS);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_inactive_next  = r_inactive;
        w_cs_n_next      = r_cs_n;
        case (r_state)
            ST_IDLE: begin
                w_cs_n_next = 1'b1;
                if (w_accept) begin
                    w_remaining_next = w_count_eff - 1'b1;
                    w_cs_n_next      = 1'b0;
                    w_state_next     = ST_TRANSFER;
                end
            end
            ST_TRANSFER: begin
                if (!r_busy) begin
                    if (r_remaining != '0) begin
                        if (w_accept) begin
                            w_remaining_next = r_remaining - 1'b1;
                        end
                    end else begin
                        w_cs_n_next     = 1'b1;
                        w_inactive_next = IW'(CS_INACTIVE_CLKS);
                        w_state_next    = ST_CS_INACTIVE;
                    end
                end
            end
            ST_CS_INACTIVE: begin
                if (r_inactive == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_inactive_next = r_inactive - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cs_n_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_inactive  <= '0;
            r_cs_n      <= 1'b1;
            r_rx_count  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_inactive  <= w_inactive_next;
            r_cs_n      <= w_cs_n_next;
            if (w_cs_n_next) begin
                r_rx_count <= '0;
            end else if (r_rx_dv) begin
                r_rx_count <= r_rx_count + 1'b1;
            end
        end
    end

    assign o_SPI_CS_n = r_cs_n;
    assign o_SPI_Clk  = r_spi_clk;
    assign o_SPI_MOSI = r_mosi;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_RX_Count = r_rx_count;
endmodule

// File: tb/tb_spi_master_with_single_cs.sv
// Scoreboard bench: instance A is mode 3 / 4 clks per half bit, instance B is mode 0 / 2 clks per half bit.
module tb_spi_master_with_single_cs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [1:0] a_tx_count, b_tx_count;
    logic [7:0] a_tx_byte, b_tx_byte;
    logic       a_tx_dv, b_tx_dv;
    logic       a_ready, b_ready;
    logic [1:0] a_rx_count, b_rx_count;
    logic       a_rx_dv, b_rx_dv;
    logic [7:0] a_rx_byte, b_rx_byte;
    logic       a_sclk, b_sclk, a_mosi, b_mosi, a_cs_n, b_cs_n;

    spi_master_with_single_cs #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4),
                                .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(10)) u_a (
        .i_Clk(clk), .i_Rst(rst_a), .i_TX_Count(a_tx_count), .i_TX_Byte(a_tx_byte),
        .i_TX_DV(a_tx_dv), .o_TX_Ready(a_ready), .o_RX_Count(a_rx_count), .o_RX_DV(a_rx_dv),
        .o_RX_Byte(a_rx_byte), .o_SPI_Clk(a_sclk), .i_SPI_MISO(a_mosi), .o_SPI_MOSI(a_mosi),
        .o_SPI_CS_n(a_cs_n));

    spi_master_with_single_cs #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2),
                                .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(10)) u_b (
        .i_Clk(clk), .i_Rst(rst_b), .i_TX_Count(b_tx_count), .i_TX_Byte(b_tx_byte),
        .i_TX_DV(b_tx_dv), .o_TX_Ready(b_ready), .o_RX_Count(b_rx_count), .o_RX_DV(b_rx_dv),
        .o_RX_Byte(b_rx_byte), .o_SPI_Clk(b_sclk), .i_SPI_MISO(b_mosi), .o_SPI_MOSI(b_mosi),
        .o_SPI_CS_n(b_cs_n));

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;
    int   a_edges = 0;
    int   a_cs_rises = 0;
    logic [7:0] b_bits = '0;
    int   b_rises = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever either DUT presents o_RX_DV.
    initial begin
        exp_t e;
        logic a_prev_clk, a_prev_cs, b_prev_clk, b_prev_cs;
        a_prev_clk = 1'b1; a_prev_cs = 1'b1; b_prev_clk = 1'b0; b_prev_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (a_sclk !== a_prev_clk) a_edges++;
            if (a_cs_n === 1'b1 && a_prev_cs === 1'b0) a_cs_rises++;
            if (b_cs_n === 1'b0 && b_prev_cs === 1'b1) begin
                b_bits  = '0;
                b_rises = 0;
            end
            if (b_cs_n === 1'b0 && b_sclk === 1'b1 && b_prev_clk === 1'b0) begin
                b_bits = {b_bits[6:0], b_mosi};
                b_rises++;
            end
            if (a_rx_dv === 1'b1) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected_rx: got byte 0x%0h, required no o_RX_DV", a_rx_byte);
                end else begin
                    e = qa.pop_front();
                    $display("rx A byte=0x%0h idx=%0d (expect 0x%0h idx=%0d)", a_rx_byte, a_rx_count, e.data, e.idx);
                    chk("a_rx_byte", int'(a_rx_byte), int'(e.data));
                    chk("a_rx_count", int'(a_rx_count), e.idx);
                end
            end
            if (b_rx_dv === 1'b1) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected_rx: got byte 0x%0h, required no o_RX_DV", b_rx_byte);
                end else begin
                    e = qb.pop_front();
                    $display("rx B byte=0x%0h idx=%0d (expect 0x%0h idx=%0d)", b_rx_byte, b_rx_count, e.data, e.idx);
                    chk("b_rx_byte", int'(b_rx_byte), int'(e.data));
                    chk("b_rx_count", int'(b_rx_count), e.idx);
                end
            end
            a_prev_clk = a_sclk; a_prev_cs = a_cs_n;
            b_prev_clk = b_sclk; b_prev_cs = b_cs_n;
        end
    end

    task automatic send_a(input logic [7:0] data, input bit push, input int idx);
        int n = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (a_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL a_ready_timeout: got ready=%b, required 1", a_ready);
        end else begin
            a_tx_byte = data;
            a_tx_dv   = 1'b1;
            if (push) qa.push_back('{data, idx});
            $display("send A byte=0x%0h", data);
            @(posedge clk);
            #1 a_tx_dv = 1'b0;
        end
    endtask

    task automatic send_b(input logic [7:0] data, input int idx);
        int n = 0;
        @(negedge clk);
        while (b_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (b_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL b_ready_timeout: got ready=%b, required 1", b_ready);
        end else begin
            b_tx_byte = data;
            b_tx_dv   = 1'b1;
            qb.push_back('{data, idx});
            $display("send B byte=0x%0h", data);
            @(posedge clk);
            #1 b_tx_dv = 1'b0;
        end
    endtask

    // Waits for CS_n to rise, then checks a gap of 10 cycles with CS high and ready low.
    task automatic gap_check_a(input string name);
        int n = 0;
        bit ok = 1'b1;
        @(negedge clk);
        while (a_cs_n !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            if (a_cs_n !== 1'b1 || a_ready !== 1'b0) ok = 1'b0;
            if (i < 9) @(negedge clk);
        end
        chk(name, int'(ok), 1);
    endtask

    initial begin
        int base_edges, base_rises, n;
        rst_a = 1'b1; rst_b = 1'b1;
        a_tx_count = 2'd2; b_tx_count = 2'd1;
        a_tx_byte = '0; b_tx_byte = '0; a_tx_dv = 1'b0; b_tx_dv = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("reset_a_cs_n", int'(a_cs_n), 1);
        chk("reset_a_sclk", int'(a_sclk), 1);
        chk("reset_a_ready", int'(a_ready), 1);
        chk("reset_a_rx_dv", int'(a_rx_dv), 0);
        chk("reset_a_rx_byte", int'(a_rx_byte), 0);
        chk("reset_a_rx_count", int'(a_rx_count), 0);
        chk("reset_a_mosi", int'(a_mosi), 0);
        chk("reset_b_sclk", int'(b_sclk), 0);
        chk("reset_b_cs_n", int'(b_cs_n), 1);

        // Burst of two bytes under one CS
        base_edges = a_edges; base_rises = a_cs_rises;
        send_a(8'hC1, 1'b1, 0);
        send_a(8'hC2, 1'b1, 1);
        gap_check_a("gap1_cs_high_ready_low");
        chk("burst1_sclk_edges", a_edges - base_edges, 32);
        chk("burst1_cs_rises", a_cs_rises - base_rises, 1);
        chk("gap1_rx_count", int'(a_rx_count), 0);

        // New burst; a request mid-byte must be ignored
        base_edges = a_edges; base_rises = a_cs_rises;
        send_a(8'hAA, 1'b1, 0);
        repeat (12) @(negedge clk);
        chk("busy_ready_low", int'(a_ready), 0);
        a_tx_byte = 8'h55; a_tx_dv = 1'b1;
        $display("pulse A byte=0x55 while busy");
        @(posedge clk);
        #1 a_tx_dv = 1'b0;
        send_a(8'h5A, 1'b1, 1);
        gap_check_a("gap2_cs_high_ready_low");
        chk("burst2_sclk_edges", a_edges - base_edges, 32);
        chk("burst2_cs_rises", a_cs_rises - base_rises, 1);

        // Mode 0, single byte burst
        send_b(8'h3C, 0);
        n = 0;
        @(negedge clk);
        while (b_rx_dv !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b_rx_dv_seen", int'(b_rx_dv === 1'b1), 1);
        @(negedge clk);
        chk("b_cs_high_after_1_byte", int'(b_cs_n), 1);
        chk("b_mosi_bits", int'(b_bits), 8'h3C);
        chk("b_sclk_rises", b_rises, 8);
        chk("b_sclk_idle_low", int'(b_sclk), 0);

        // Reset during bit 4 of a burst
        repeat (20) @(negedge clk);
        send_a(8'h81, 1'b0, 0);
        repeat (36) @(negedge clk);
        chk("midrst_cs_low_before", int'(a_cs_n), 0);
        rst_a = 1'b1;
        @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", int'(a_cs_n), 1);
        chk("midrst_sclk", int'(a_sclk), 1);
        chk("midrst_rx_dv", int'(a_rx_dv), 0);
        chk("midrst_mosi", int'(a_mosi), 0);
        repeat (200) @(negedge clk);
        chk("midrst_ready_after", int'(a_ready), 1);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
